// File: rtl/lzc_norm_pipe_if.sv
// Handshake bundle for lzc_norm_pipe: input word/tag channel and result channel.
// master = producer/consumer side, slave = the leading-zero pipeline itself.
interface lzc_norm_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    lz_cnt;
   logic [CW:0]      shift_amt;
   logic             zero;
   logic [WIDTH-1:0] norm_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, lz_cnt, shift_amt, zero, norm_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, lz_cnt, shift_amt, zero, norm_data, out_tag
   );
endinterface

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero counter / normaliser (1 or 2 stages, valid/ready).
// Optional barrel shifter for norm_data enabled by macro LZC_NORM_SHIFT_EN.
module lzc_norm_pipe #(
   parameter int WIDTH  = 32,
   parameter int OFFSET = 9,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input logic             clk,
   input logic             rst,
   lzc_norm_pipe_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int NG = WIDTH / 8;
   localparam logic [CW:0] OFF_V = (CW+1)'(OFFSET);

   // Handshake: a word moves on any clock edge where valid & ready are both high;
   // valid never waits on ready, and a held result keeps every output stable.

   function automatic logic [2:0] byte_lz(input logic [7:0] b);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = 3'(7 - i);
      end
      return r;
   endfunction

   // Highest nonempty group wins; all groups empty means the full width.
   function automatic logic [CW-1:0] resolve(input logic [NG-1:0]   gv,
                                             input logic [3*NG-1:0] glz);
      logic [CW-1:0] r;
      r = CW'(WIDTH);
      for (int g = 0; g < NG; g++) begin
         if (gv[g]) r = CW'((NG - 1 - g) * 8) + CW'(glz[3*g +: 3]);
      end
      return r;
   endfunction

   logic [NG-1:0]   gv_in;
   logic [3*NG-1:0] glz_in;

   always_comb begin
      gv_in  = '0;
      glz_in = '0;
      for (int g = 0; g < NG; g++) begin
         gv_in[g]         = |bus.in_data[8*g +: 8];
         glz_in[3*g +: 3] = byte_lz(bus.in_data[8*g +: 8]);
      end
   end

   logic             src_valid;
   logic [TAG_W-1:0] src_tag;
   logic [NG-1:0]    src_gv;
   logic [3*NG-1:0]  src_glz;
`ifdef LZC_NORM_SHIFT_EN
   logic [WIDTH-1:0] src_data;
`endif
   logic             acc_ready;
   logic             out_v;
   logic             adv_out;

   assign adv_out      = !out_v || bus.out_ready;
   assign bus.in_ready = acc_ready;

   generate
      if (STAGES == 2) begin : g_two
         logic             v1;
         logic [TAG_W-1:0] t1;
         logic [NG-1:0]    gv1;
         logic [3*NG-1:0]  glz1;

         assign acc_ready = !v1 || adv_out;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v1   <= 1'b0;
               t1   <= '0;
               gv1  <= '0;
               glz1 <= '0;
            end else if (acc_ready) begin
               v1 <= bus.in_valid;
               if (bus.in_valid) begin
                  t1   <= bus.in_tag;
                  gv1  <= gv_in;
                  glz1 <= glz_in;
               end
            end
         end

`ifdef LZC_NORM_SHIFT_EN
         // The raw word is only needed downstream when the shifter exists.
         logic [WIDTH-1:0] d1;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d1 <= '0;
            end else if (acc_ready && bus.in_valid) begin
               d1 <= bus.in_data;
            end
         end
         assign src_data = d1;
`endif

         assign src_valid = v1;
         assign src_tag   = t1;
         assign src_gv    = gv1;
         assign src_glz   = glz1;
      end else begin : g_one
         assign acc_ready = adv_out;
         assign src_valid = bus.in_valid;
         assign src_tag   = bus.in_tag;
         assign src_gv    = gv_in;
         assign src_glz   = glz_in;
`ifdef LZC_NORM_SHIFT_EN
         assign src_data  = bus.in_data;
`endif
      end
   endgenerate

   logic [CW-1:0]    lz_next;
   logic [CW-1:0]    lz_r;
   logic [CW:0]      sh_r;
   logic             zero_r;
   logic [TAG_W-1:0] tag_r;

   assign lz_next = resolve(src_gv, src_glz);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_v  <= 1'b0;
         lz_r   <= '0;
         sh_r   <= '0;
         zero_r <= 1'b0;
         tag_r  <= '0;
      end else if (adv_out) begin
         out_v <= src_valid;
         if (src_valid) begin
            lz_r   <= lz_next;
            sh_r   <= {1'b0, lz_next} - OFF_V;
            zero_r <= ~|src_gv;
            tag_r  <= src_tag;
         end
      end
   end

`ifdef LZC_NORM_SHIFT_EN
   // Shift by the full width (all-zero input) naturally yields zero.
   logic [WIDTH-1:0] norm_r;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         norm_r <= '0;
      end else if (adv_out && src_valid) begin
         norm_r <= src_data << lz_next;
      end
   end
   assign bus.norm_data = norm_r;
`else
   assign bus.norm_data = '0;
`endif

   assign bus.out_valid = out_v;
   assign bus.lz_cnt    = lz_r;
   assign bus.shift_amt = sh_r;
   assign bus.zero      = zero_r;
   assign bus.out_tag   = tag_r;
endmodule
